// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data memory for the MEM stage: accepts one load/store,
// inserts LATENCY wait states, then pulses Ready (and Err for bad requests).
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Stall,
  output logic        Err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    bad_q, bad_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;

  logic [31:0]             mem_q [DEPTH];

  logic                    req_c;
  logic                    in_bad_c;
  logic [ADDR_WIDTH-1:0]   in_idx_c;
  logic                    acc_go_c;
  logic                    acc_rd_c;
  logic                    acc_wr_c;
  logic                    acc_bad_c;
  logic [ADDR_WIDTH-1:0]   acc_idx_c;
  logic [31:0]             acc_wdata_c;
  logic                    mem_we_c;
  logic                    unused_addr_c;

  assign req_c         = MemRead | MemWrite;
  assign in_bad_c      = (Address[1:0] != 2'b00) | (MemRead & MemWrite);
  assign in_idx_c      = Address[ADDR_WIDTH+1:2];
  assign unused_addr_c = ^Address[31:ADDR_WIDTH+2];

  // Next-state, request latching and access control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    bad_d       = bad_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    acc_go_c    = 1'b0;
    acc_rd_c    = rd_q;
    acc_wr_c    = wr_q;
    acc_bad_c   = bad_q;
    acc_idx_c   = idx_q;
    acc_wdata_c = wdata_q;
    mem_we_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          rd_d    = MemRead;
          wr_d    = MemWrite;
          bad_d   = in_bad_c;
          idx_d   = in_idx_c;
          wdata_d = WriteData;
          cnt_d   = CNT_W'(LATENCY);
          if (LATENCY == 0) begin
            // Zero wait states: commit straight from the live request.
            state_d     = RESP;
            acc_go_c    = 1'b1;
            acc_rd_c    = MemRead;
            acc_wr_c    = MemWrite;
            acc_bad_c   = in_bad_c;
            acc_idx_c   = in_idx_c;
            acc_wdata_c = WriteData;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          acc_go_c = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Erroneous accesses neither read nor write and return zero data.
    if (acc_go_c) begin
      ready_d = 1'b1;
      err_d   = acc_bad_c;
      if (acc_bad_c) begin
        rdata_d = 32'd0;
      end else if (acc_rd_c) begin
        rdata_d = mem_q[acc_idx_c];
      end
      mem_we_c = acc_wr_c & ~acc_bad_c & ~reset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[acc_idx_c] <= acc_wdata_c;
    end
  end

  assign ReadData = rdata_q;
  assign Ready    = ready_q;
  assign Err      = err_q;
  assign Stall    = req_c & ~ready_q & ~reset;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 0, 4) driven with directed accesses.
module tb_dmem_responder;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mr [3];
  logic        mw [3];
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  logic [31:0] rd [3];
  logic        rdy [3];
  logic        stl [3];
  logic        er [3];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .MemRead(mr[0]), .MemWrite(mw[0]), .Address(ad[0]),
    .WriteData(wd[0]), .ReadData(rd[0]), .Ready(rdy[0]), .Stall(stl[0]), .Err(er[0]));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .MemRead(mr[1]), .MemWrite(mw[1]), .Address(ad[1]),
    .WriteData(wd[1]), .ReadData(rd[1]), .Ready(rdy[1]), .Stall(stl[1]), .Err(er[1]));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .MemRead(mr[2]), .MemWrite(mw[2]), .Address(ad[2]),
    .WriteData(wd[2]), .ReadData(rd[2]), .Ready(rdy[2]), .Stall(stl[2]), .Err(er[2]));

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 4);
  endfunction

  // Monitor: every Ready pulse pops the matching expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rdy[d] === 1'b1) begin
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : ((d == 1) ? q1.size() : q2.size());
        if (n == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready dut%0d: got Ready=1 expected no response (cycle %0d)", d, cyc);
        end else begin
          if (d == 0) e = q0.pop_front();
          else if (d == 1) e = q1.pop_front();
          else e = q2.pop_front();
          check($sformatf("ready_cycle dut%0d", d), 32'(cyc), 32'(e.cyc));
          check($sformatf("err dut%0d", d), 32'(er[d]), 32'(e.err));
          if (e.chk_rd) check($sformatf("rdata dut%0d", d), rd[d], e.rdata);
        end
      end
    end
  end

  // Issue one access starting now (just after an edge); ends just after the edge following Ready.
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wdat, input logic [31:0] erd, input logic eerr,
                        input logic chk);
    exp_t e;
    int   scnt;
    bit   done;
    int   lat;
    lat = lat_of(d);
    mr[d] = r;
    mw[d] = w;
    ad[d] = a;
    wd[d] = wdat;
    e.cyc = cyc + lat + 1;
    e.rdata = erd;
    e.err = eerr;
    e.chk_rd = chk;
    if (d == 0) q0.push_back(e);
    else if (d == 1) q1.push_back(e);
    else q2.push_back(e);
    scnt = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) done = 1'b1;
      else if (stl[d] === 1'b1) scnt++;
    end
    check($sformatf("ready_seen dut%0d addr %h", d, a), 32'(done), 32'd1);
    check($sformatf("stall_cycles dut%0d", d), 32'(scnt), 32'(lat + 1));
    check($sformatf("stall_low_at_ready dut%0d", d), 32'(stl[d]), 32'd0);
    @(posedge clk);
    #1;
    mr[d] = 1'b0;
    mw[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      mr[d] = 1'b0;
      mw[d] = 1'b0;
      ad[d] = 32'd0;
      wd[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_rdata dut%0d", d), rd[d], 32'd0);
      check($sformatf("reset_ready dut%0d", d), 32'(rdy[d]), 32'd0);
      check($sformatf("reset_err dut%0d", d), 32'(er[d]), 32'd0);
      check($sformatf("reset_stall dut%0d", d), 32'(stl[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Store then load, LATENCY 2
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    // Misaligned store leaves word 4 intact
    access(0, 1'b0, 1'b1, 32'h12, 32'h5, 32'h0, 1'b1, 1'b1);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    // Conflicting request on word 8
    access(0, 1'b0, 1'b1, 32'h20, 32'hA5A50008, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A50008, 1'b0, 1'b1);
    access(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A50008, 1'b0, 1'b1);
    // Address wrap
    access(0, 1'b0, 1'b1, 32'h1004, 32'h1234, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0004, 32'h0, 32'h1234, 1'b0, 1'b1);

    // Zero latency, back-to-back
    access(1, 1'b0, 1'b1, 32'h8, 32'h77, 32'h0, 1'b0, 1'b0);
    access(1, 1'b1, 1'b0, 32'h8, 32'h0, 32'h77, 1'b0, 1'b1);
    access(1, 1'b1, 1'b0, 32'h8, 32'h0, 32'h77, 1'b0, 1'b1);
    access(1, 1'b1, 1'b0, 32'h9, 32'h0, 32'h0, 1'b1, 1'b1);

    // Reset mid-access, LATENCY 4
    access(2, 1'b0, 1'b1, 32'h30, 32'h1111, 32'h0, 1'b0, 1'b0);
    access(2, 1'b1, 1'b0, 32'h30, 32'h0, 32'h1111, 1'b0, 1'b1);
    mw[2] = 1'b1;
    ad[2] = 32'h30;
    wd[2] = 32'hCAFE;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_rdata", rd[2], 32'd0);
    check("midreset_ready", 32'(rdy[2]), 32'd0);
    check("midreset_err", 32'(er[2]), 32'd0);
    check("midreset_stall", 32'(stl[2]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mw[2] = 1'b0;
    access(2, 1'b1, 1'b0, 32'h30, 32'h0, 32'h1111, 1'b0, 1'b1);

    repeat (4) @(posedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
